// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the 5-bit-opcode processor.
// Outputs are decoded from registered state; only branch pc_sel in EXECUTE looks at live ALU flags.
module multicycle_control #(
   parameter int OPC_W      = 5,
   parameter int MD_TIMEOUT = 40
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [OPC_W-1:0] opcode,
   input  logic [OPC_W-1:0] alu_op,
   input  logic             alu_ovf,
   input  logic             alu_ne,
   input  logic             alu_lt,
   input  logic             md_ready,
   input  logic             md_exc,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             alu_insel,
   output logic [OPC_W-1:0] final_alu_op,
   output logic             md_mult,
   output logic             md_div,
   output logic             dm_we,
   output logic             rf_we,
   output logic [1:0]       rf_dst_sel,
   output logic [1:0]       wb_sel,
   output logic [2:0]       exc_code,
   output logic             instr_done
);
   localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

   localparam logic [OPC_W-1:0] OP_R    = OPC_W'(5'b00000);
   localparam logic [OPC_W-1:0] OP_J    = OPC_W'(5'b00001);
   localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(5'b00010);
   localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(5'b00011);
   localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(5'b00100);
   localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b00101);
   localparam logic [OPC_W-1:0] OP_BLT  = OPC_W'(5'b00110);
   localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(5'b00111);
   localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(5'b01000);
   localparam logic [OPC_W-1:0] OP_SETX = OPC_W'(5'b10101);
   localparam logic [OPC_W-1:0] OP_BEX  = OPC_W'(5'b10110);

   localparam logic [OPC_W-1:0] ALU_ADD = OPC_W'(5'b00000);
   localparam logic [OPC_W-1:0] ALU_SUB = OPC_W'(5'b00001);
   localparam logic [OPC_W-1:0] ALU_MUL = OPC_W'(5'b00110);
   localparam logic [OPC_W-1:0] ALU_DIV = OPC_W'(5'b00111);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MD_WAIT, S_MEM, S_WRITEBACK
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] md_cnt_r;
   logic             exc_pend_r;
   logic [2:0]       exc_code_r;

   logic is_r_s, is_mul_s, is_div_s, is_addi_s, is_lw_s, is_sw_s;
   logic is_cmp_s, ends_exe_s, ovf_hit_s;
   logic [2:0] ovf_code_s, md_code_s;

   assign is_r_s     = (opcode == OP_R);
   assign is_mul_s   = is_r_s && (alu_op == ALU_MUL);
   assign is_div_s   = is_r_s && (alu_op == ALU_DIV);
   assign is_addi_s  = (opcode == OP_ADDI);
   assign is_lw_s    = (opcode == OP_LW);
   assign is_sw_s    = (opcode == OP_SW);
   assign is_cmp_s   = (opcode == OP_BNE) || (opcode == OP_BLT) || (opcode == OP_BEX);
   assign ends_exe_s = !(is_r_s || is_addi_s || is_lw_s || is_sw_s);
   // Only add, sub and addi raise an arithmetic overflow exception.
   assign ovf_hit_s  = alu_ovf && (is_addi_s ||
                       (is_r_s && ((alu_op == ALU_ADD) || (alu_op == ALU_SUB))));
   assign ovf_code_s = is_addi_s ? 3'd2 : ((alu_op == ALU_ADD) ? 3'd1 : 3'd3);
   assign md_code_s  = is_div_s ? 3'd5 : 3'd4;

   // State sequencing, multdiv timeout counter and pending-exception latch.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= S_FETCH;
         md_cnt_r   <= {CNT_W{1'b0}};
         exc_pend_r <= 1'b0;
         exc_code_r <= 3'd0;
      end else begin
         case (state_r)
            S_FETCH: begin
               state_r    <= S_DECODE;
               md_cnt_r   <= {CNT_W{1'b0}};
               exc_pend_r <= 1'b0;
            end
            S_DECODE: state_r <= S_EXECUTE;
            S_EXECUTE: begin
               if (is_mul_s || is_div_s) begin
                  state_r  <= S_MD_WAIT;
                  md_cnt_r <= {CNT_W{1'b0}};
               end else if (ends_exe_s) begin
                  state_r <= S_FETCH;
               end else if (is_lw_s || is_sw_s) begin
                  state_r <= S_MEM;
               end else begin
                  state_r    <= S_WRITEBACK;
                  exc_pend_r <= ovf_hit_s;
                  exc_code_r <= ovf_code_s;
               end
            end
            S_MD_WAIT: begin
               // A result arriving on the timeout cycle takes priority over the timeout.
               if (md_ready) begin
                  state_r    <= S_WRITEBACK;
                  exc_pend_r <= md_exc;
                  exc_code_r <= md_code_s;
               end else if (md_cnt_r == CNT_W'(MD_TIMEOUT - 1)) begin
                  state_r    <= S_WRITEBACK;
                  exc_pend_r <= 1'b1;
                  exc_code_r <= md_code_s;
               end else begin
                  md_cnt_r <= md_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            S_MEM:       state_r <= is_sw_s ? S_FETCH : S_WRITEBACK;
            S_WRITEBACK: state_r <= S_FETCH;
            default:     state_r <= S_FETCH;
         endcase
      end
   end

   // Datapath control decode; everything is forced low while reset is asserted.
   always_comb begin
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'b00;
      alu_insel    = 1'b0;
      final_alu_op = {OPC_W{1'b0}};
      md_mult      = 1'b0;
      md_div       = 1'b0;
      dm_we        = 1'b0;
      rf_we        = 1'b0;
      rf_dst_sel   = 2'b00;
      wb_sel       = 2'b00;
      exc_code     = 3'd0;
      instr_done   = 1'b0;
      if (reset) begin
         ir_we = 1'b0;
      end else begin
         // ALU controls are held from EXECUTE until the instruction retires.
         if ((state_r != S_FETCH) && (state_r != S_DECODE)) begin
            alu_insel    = is_addi_s || is_lw_s || is_sw_s;
            final_alu_op = is_r_s ? alu_op : (is_cmp_s ? ALU_SUB : {OPC_W{1'b0}});
         end else begin
            alu_insel    = 1'b0;
         end
         case (state_r)
            S_FETCH: ir_we = 1'b1;
            S_EXECUTE: begin
               md_mult    = is_mul_s;
               md_div     = is_div_s;
               pc_we      = ends_exe_s;
               instr_done = ends_exe_s;
               case (opcode)
                  OP_J:    pc_sel = 2'b10;
                  OP_JAL: begin
                     pc_sel     = 2'b10;
                     rf_we      = 1'b1;
                     rf_dst_sel = 2'b01;
                     wb_sel     = 2'b10;
                  end
                  OP_JR:   pc_sel = 2'b11;
                  OP_BNE:  pc_sel = alu_ne ? 2'b01 : 2'b00;
                  OP_BLT:  pc_sel = alu_lt ? 2'b01 : 2'b00;
                  OP_BEX:  pc_sel = alu_ne ? 2'b10 : 2'b00;
                  OP_SETX: begin
                     rf_we      = 1'b1;
                     rf_dst_sel = 2'b10;
                  end
                  default: pc_sel = 2'b00;
               endcase
            end
            S_MEM: begin
               dm_we      = is_sw_s;
               pc_we      = is_sw_s;
               instr_done = is_sw_s;
            end
            S_WRITEBACK: begin
               rf_we      = 1'b1;
               pc_we      = 1'b1;
               instr_done = 1'b1;
               if (is_lw_s) begin
                  wb_sel = 2'b01;
               end else if (exc_pend_r) begin
                  rf_dst_sel = 2'b10;
                  wb_sel     = 2'b11;
                  exc_code   = exc_code_r;
               end else begin
                  wb_sel = 2'b00;
               end
            end
            default: ir_we = 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-instruction cycle-trace model built from the
// instruction-level rules, compared against the DUT on every cycle.
module tb_multicycle_control;
   localparam int MD_TIMEOUT = 40;

   typedef struct packed {
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_sel;
      logic       alu_insel;
      logic [4:0] final_alu_op;
      logic       md_mult;
      logic       md_div;
      logic       dm_we;
      logic       rf_we;
      logic [1:0] rf_dst_sel;
      logic [1:0] wb_sel;
      logic [2:0] exc_code;
      logic       instr_done;
   } out_t;

   logic clock = 1'b0;
   logic reset;
   logic [4:0] opcode, alu_op;
   logic alu_ovf, alu_ne, alu_lt, md_ready, md_exc;
   logic ir_we, pc_we, alu_insel, md_mult, md_div, dm_we, rf_we, instr_done;
   logic [1:0] pc_sel, rf_dst_sel, wb_sel;
   logic [4:0] final_alu_op;
   logic [2:0] exc_code;

   int    checks = 0;
   int    failures = 0;
   bit    chk_en = 1'b0;
   out_t  exp_out;
   out_t  act;
   out_t  trace[$];
   string tname = "reset";
   int    cyc = 0;

   always #5 clock = ~clock;

   multicycle_control #(.OPC_W(5), .MD_TIMEOUT(MD_TIMEOUT)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .alu_op(alu_op),
      .alu_ovf(alu_ovf), .alu_ne(alu_ne), .alu_lt(alu_lt),
      .md_ready(md_ready), .md_exc(md_exc),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_insel(alu_insel),
      .final_alu_op(final_alu_op), .md_mult(md_mult), .md_div(md_div),
      .dm_we(dm_we), .rf_we(rf_we), .rf_dst_sel(rf_dst_sel), .wb_sel(wb_sel),
      .exc_code(exc_code), .instr_done(instr_done)
   );

   assign act = {ir_we, pc_we, pc_sel, alu_insel, final_alu_op, md_mult, md_div,
                 dm_we, rf_we, rf_dst_sel, wb_sel, exc_code, instr_done};

   // Per-cycle comparison of every output against the model trace.
   always @(negedge clock) begin
      if (chk_en) begin
         checks++;
         if (act !== exp_out) begin
            failures++;
            $display("FAIL %s cyc%0d outputs act=%h exp=%h", tname, cyc, act, exp_out);
         end
      end
   end

   task automatic check(input string nm, input int a, input int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d", nm, a, e);
      end
   endtask

   function automatic out_t wb_cycle(input out_t base, input bit exc,
                                     input logic [2:0] code, input logic [1:0] wbs);
      out_t c = base;
      c.rf_we = 1'b1; c.pc_we = 1'b1; c.instr_done = 1'b1; c.pc_sel = 2'b00;
      if (exc) begin
         c.rf_dst_sel = 2'b10; c.wb_sel = 2'b11; c.exc_code = code;
      end else begin
         c.wb_sel = wbs;
      end
      return c;
   endfunction

   // Instruction-level model: list of expected outputs, one entry per cycle.
   task automatic build(input logic [4:0] opc, input logic [4:0] aop, input logic ovf,
                        input logic ne, input logic lt, input int md_at, input logic mdx);
      out_t c, alu;
      bit   ready_in_time;
      int   waits;
      trace.delete();
      c = '0; c.ir_we = 1'b1; trace.push_back(c);
      c = '0; trace.push_back(c);
      alu = '0;
      alu.final_alu_op = (opc == 5'd0) ? aop :
                         ((opc == 5'd2 || opc == 5'd6 || opc == 5'd22) ? 5'd1 : 5'd0);
      alu.alu_insel = (opc == 5'd5 || opc == 5'd7 || opc == 5'd8);
      c = alu;
      if (opc == 5'd0 && (aop == 5'd6 || aop == 5'd7)) begin
         if (aop == 5'd6) c.md_mult = 1'b1; else c.md_div = 1'b1;
         trace.push_back(c);
         ready_in_time = (md_at >= 0 && md_at < MD_TIMEOUT);
         waits = ready_in_time ? md_at + 1 : MD_TIMEOUT;
         for (int i = 0; i < waits; i++) trace.push_back(alu);
         trace.push_back(wb_cycle(alu, ready_in_time ? mdx : 1'b1,
                                  (aop == 5'd6) ? 3'd4 : 3'd5, 2'b00));
      end else if (opc == 5'd0 || opc == 5'd5) begin
         trace.push_back(c);
         trace.push_back(wb_cycle(alu, ovf && (opc == 5'd5 || aop == 5'd0 || aop == 5'd1),
                                  (opc == 5'd5) ? 3'd2 : ((aop == 5'd0) ? 3'd1 : 3'd3), 2'b00));
      end else if (opc == 5'd8) begin
         trace.push_back(c);
         trace.push_back(alu);
         trace.push_back(wb_cycle(alu, 1'b0, 3'd0, 2'b01));
      end else if (opc == 5'd7) begin
         trace.push_back(c);
         c.dm_we = 1'b1; c.pc_we = 1'b1; c.instr_done = 1'b1;
         trace.push_back(c);
      end else begin
         c.pc_we = 1'b1; c.instr_done = 1'b1;
         case (opc)
            5'd1:  c.pc_sel = 2'b10;
            5'd3:  begin c.pc_sel = 2'b10; c.rf_we = 1'b1; c.rf_dst_sel = 2'b01; c.wb_sel = 2'b10; end
            5'd4:  c.pc_sel = 2'b11;
            5'd2:  c.pc_sel = ne ? 2'b01 : 2'b00;
            5'd6:  c.pc_sel = lt ? 2'b01 : 2'b00;
            5'd22: c.pc_sel = ne ? 2'b10 : 2'b00;
            5'd21: begin c.rf_we = 1'b1; c.rf_dst_sel = 2'b10; end
            default: c.pc_sel = 2'b00;
         endcase
         trace.push_back(c);
      end
   endtask

   task automatic run(input string nm, input logic [4:0] opc, input logic [4:0] aop,
                      input logic ovf, input logic ne, input logic lt, input int md_at,
                      input logic mdx, input int exp_len, input logic [9:0] exp_pin,
                      input int cut);
      out_t last;
      int   n, pcw, done_at;
      build(opc, aop, ovf, ne, lt, md_at, mdx);
      last = trace[trace.size() - 1];
      check({nm, " model_len"}, trace.size(), exp_len);
      check({nm, " model_pin"}, int'({last.pc_sel, last.rf_we, last.rf_dst_sel,
                                     last.wb_sel, last.exc_code}), int'(exp_pin));
      tname = nm;
      n = (cut >= 0) ? cut : trace.size();
      pcw = 0;
      done_at = -1;
      for (int k = 0; k < n; k++) begin
         cyc = k;
         opcode = opc; alu_op = aop; alu_ovf = ovf; alu_ne = ne; alu_lt = lt;
         md_exc = mdx;
         md_ready = (md_at >= 0) && (k == 3 + md_at);
         exp_out = trace[k];
         chk_en = 1'b1;
         @(negedge clock);
         if (pc_we) pcw++;
         if (instr_done && done_at < 0) done_at = k;
         @(posedge clock);
         #1;
      end
      md_ready = 1'b0;
      if (cut < 0) begin
         check({nm, " pc_we_pulses"}, pcw, 1);
         check({nm, " done_cycle"}, done_at, exp_len - 1);
      end
   endtask

   task automatic hold_reset(input string nm, input int n);
      tname = nm;
      reset = 1'b1;
      for (int k = 0; k < n; k++) begin
         cyc = k;
         exp_out = '0;
         chk_en = 1'b1;
         @(negedge clock);
         @(posedge clock);
         #1;
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; opcode = 5'd0; alu_op = 5'd0; alu_ovf = 1'b0; alu_ne = 1'b0;
      alu_lt = 1'b0; md_ready = 1'b0; md_exc = 1'b0;
      @(posedge clock); #1;
      hold_reset("reset", 2);
      //   name           opc     aop    ovf   ne    lt  md_at mdx len pin{pc_sel,rf_we,dst,wb,code}
      run("add",        5'd0,  5'd0,  1'b0, 1'b0, 1'b0, -1, 1'b0, 4, 10'b00_1_00_00_000, -1);
      run("add_ovf",    5'd0,  5'd0,  1'b1, 1'b0, 1'b0, -1, 1'b0, 4, 10'b00_1_10_11_001, -1);
      run("addi_ovf",   5'd5,  5'd0,  1'b1, 1'b0, 1'b0, -1, 1'b0, 4, 10'b00_1_10_11_010, -1);
      run("sub_ovf",    5'd0,  5'd1,  1'b1, 1'b0, 1'b0, -1, 1'b0, 4, 10'b00_1_10_11_011, -1);
      run("and_ovf",    5'd0,  5'd2,  1'b1, 1'b0, 1'b0, -1, 1'b0, 4, 10'b00_1_00_00_000, -1);
      run("lw",         5'd8,  5'd0,  1'b0, 1'b0, 1'b0, -1, 1'b0, 5, 10'b00_1_00_01_000, -1);
      run("sw",         5'd7,  5'd0,  1'b0, 1'b0, 1'b0, -1, 1'b0, 4, 10'b00_0_00_00_000, -1);
      run("mul_rdy",    5'd0,  5'd6,  1'b0, 1'b0, 1'b0,  6, 1'b0, 11, 10'b00_1_00_00_000, -1);
      run("div_exc",    5'd0,  5'd7,  1'b0, 1'b0, 1'b0,  2, 1'b1, 7, 10'b00_1_10_11_101, -1);
      run("mul_tmo",    5'd0,  5'd6,  1'b0, 1'b0, 1'b0, -1, 1'b0, 44, 10'b00_1_10_11_100, -1);
      run("div_tmo",    5'd0,  5'd7,  1'b0, 1'b0, 1'b0, -1, 1'b0, 44, 10'b00_1_10_11_101, -1);
      run("mul_rdy_tmo",5'd0,  5'd6,  1'b0, 1'b0, 1'b0, 39, 1'b0, 44, 10'b00_1_00_00_000, -1);
      run("bne_taken",  5'd2,  5'd0,  1'b0, 1'b1, 1'b0, -1, 1'b0, 3, 10'b01_0_00_00_000, -1);
      run("bne_not",    5'd2,  5'd0,  1'b0, 1'b0, 1'b1, -1, 1'b0, 3, 10'b00_0_00_00_000, -1);
      run("blt_taken",  5'd6,  5'd0,  1'b0, 1'b0, 1'b1, -1, 1'b0, 3, 10'b01_0_00_00_000, -1);
      run("blt_not",    5'd6,  5'd0,  1'b0, 1'b1, 1'b0, -1, 1'b0, 3, 10'b00_0_00_00_000, -1);
      run("bex_taken",  5'd22, 5'd0,  1'b0, 1'b1, 1'b0, -1, 1'b0, 3, 10'b10_0_00_00_000, -1);
      run("bex_not",    5'd22, 5'd0,  1'b0, 1'b0, 1'b1, -1, 1'b0, 3, 10'b00_0_00_00_000, -1);
      run("j",          5'd1,  5'd0,  1'b0, 1'b0, 1'b0, -1, 1'b0, 3, 10'b10_0_00_00_000, -1);
      run("jal",        5'd3,  5'd0,  1'b0, 1'b0, 1'b0, -1, 1'b0, 3, 10'b10_1_01_10_000, -1);
      run("jr",         5'd4,  5'd0,  1'b0, 1'b0, 1'b0, -1, 1'b0, 3, 10'b11_0_00_00_000, -1);
      run("setx",       5'd21, 5'd0,  1'b0, 1'b0, 1'b0, -1, 1'b0, 3, 10'b00_1_10_00_000, -1);
      run("nop",        5'd31, 5'd0,  1'b0, 1'b1, 1'b1, -1, 1'b0, 3, 10'b00_0_00_00_000, -1);
      // lw interrupted on its writeback cycle: reset must suppress the register write.
      run("lw_cut",     5'd8,  5'd0,  1'b0, 1'b0, 1'b0, -1, 1'b0, 5, 10'b00_1_00_01_000, 4);
      hold_reset("reset_mid_lw", 3);
      run("add_after",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, -1, 1'b0, 4, 10'b00_1_00_00_000, -1);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
